// File: rtl/mem_map_pkg.sv
// Memory map constants and FSM state type shared by the copy master and
// its bench.
//   ROM_LO..ROM_HI : read-only region (legal copy source, never a target)
//   RAM_LO..RAM_HI : read/write region (legal source and destination)
//   copy_state_t   : state encoding of the copy FSM, also used on the
//                    state_dbg port
package mem_map_pkg;

  localparam logic [31:0] ROM_LO = 32'd0;
  localparam logic [31:0] ROM_HI = 32'd152099;
  localparam logic [31:0] RAM_LO = 32'd152100;
  localparam logic [31:0] RAM_HI = 32'd305735;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } copy_state_t;

endpackage

// File: rtl/mem_copy_master_if.sv
// Word-wide memory bus between the copy master and a memory controller.
//   mem_addr : word address (master -> slave)
//   mem_we   : write strobe (master -> slave)
//   mem_wd   : write data (master -> slave)
//   mem_rd   : read data for mem_addr, combinational (slave -> master)
//
// Handshake: there is no valid/ready pair. The slave is always ready. A
// write takes place at the rising edge that ends a cycle with mem_we=1.
// When mem_we=0, mem_rd must be valid for mem_addr within the same cycle,
// and the master samples it at the rising edge that ends that cycle.
interface mem_copy_master_if;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/copy_checksum.sv
// 32-bit clearable accumulator. The result is the running modulo-2^32 sum
// of the words that are added.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clears the sum; takes priority over add_en
//   add_en     : adds add_val to the sum at the rising edge
//   add_val    : word to add
//   sum        : registered running sum
module copy_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] sum
);

  logic [31:0] sum_d;
  logic [31:0] sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine. It checks the requested range, then
// repeats a READ then WRITE cycle pair for each word.
// Optional feature macro: MEM_COPY_CHECKSUM_EN. When it is defined, checksum
// holds the running sum of the words copied by the last request. When it is
// undefined, checksum is tied to 0.
//   clk, reset       : clock and synchronous active-high reset
//   start            : request pulse, accepted only in IDLE
//   src_addr         : first source word address, captured on an accepted start
//   dst_addr         : first destination word address, captured on an accepted start
//   length           : word count, captured on an accepted start
//   busy, done       : activity flag and one-cycle completion pulse
//   error            : range violation on the last request, held until the next start
//   checksum         : sum of the words copied (0 when the feature is off)
//   mem              : memory bus, master side
//   state_dbg        : current FSM state
module mem_copy_master #(
  parameter logic [31:0] RAM_LO = mem_map_pkg::RAM_LO,
  parameter logic [31:0] RAM_HI = mem_map_pkg::RAM_HI
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              src_addr,
  input  logic [31:0]              dst_addr,
  input  logic [31:0]              length,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [31:0]              checksum,
  mem_copy_master_if.master        mem,
  output mem_map_pkg::copy_state_t state_dbg
);

  import mem_map_pkg::*;

  copy_state_t state_d,   state_q;
  logic [31:0] src_ptr_d, src_ptr_q;
  logic [31:0] dst_ptr_d, dst_ptr_q;
  logic [31:0] count_d,   count_q;
  logic        busy_d,    busy_q;
  logic        done_d,    done_q;
  logic        error_d,   error_q;
  logic [31:0] mem_addr_d, mem_addr_q;
  logic        mem_we_d,   mem_we_q;
  // mem_wd_q is the data register: it captures mem_rd at the READ edge and
  // then drives the write data during WRITE.
  logic [31:0] mem_wd_d,   mem_wd_q;

  // The range arithmetic uses 33 bits, so a wrap past 2^32 shows up as a
  // value above RAM_HI instead of wrapping back into range. The end-address
  // checks apply only for a non-empty copy. Otherwise length-1 would
  // underflow and a zero-length request would be flagged.
  logic [32:0] dst_end;
  logic [32:0] src_end;
  logic        range_err;

  assign dst_end   = {1'b0, dst_ptr_q} + {1'b0, count_q} - 33'd1;
  assign src_end   = {1'b0, src_ptr_q} + {1'b0, count_q} - 33'd1;
  assign range_err = (dst_ptr_q < RAM_LO) ||
                     ((count_q != 32'd0) &&
                      ((dst_end > {1'b0, RAM_HI}) || (src_end > {1'b0, RAM_HI})));

  // Bus outputs are computed from the next state, so each registered output
  // matches the state it belongs to.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    mem_addr_d = '0;
    mem_we_d   = 1'b0;
    mem_wd_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          count_d   = length;
          busy_d    = 1'b1;
          error_d   = 1'b0;
        end
      end

      S_CHECK: begin
        if (range_err) begin
          state_d = S_DONE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else if (count_q == 32'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_READ;
          mem_addr_d = src_ptr_q;
        end
      end

      S_READ: begin
        state_d    = S_WRITE;
        mem_addr_d = dst_ptr_q;
        mem_we_d   = 1'b1;
        mem_wd_d   = mem.mem_rd;
      end

      S_WRITE: begin
        src_ptr_d = src_ptr_q + 32'd1;
        dst_ptr_d = dst_ptr_q + 32'd1;
        count_d   = count_q - 32'd1;
        if (count_q == 32'd1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_READ;
          mem_addr_d = src_ptr_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic ck_clr;
  logic ck_add;

  assign ck_clr = (state_q == S_IDLE) && start;
  assign ck_add = (state_q == S_READ);

  copy_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .clr     (ck_clr),
    .add_en  (ck_add),
    .add_val (mem.mem_rd),
    .sum     (checksum)
  );
`else
  assign checksum = '0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.mem_wd   = mem_wd_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master. The memory model returns addr+1 as read data,
// so ROM words 0..3 read as 1..4.
// Expected writes and completions are queued when a request is issued. A
// negedge monitor pops and compares them when mem_we or done appears.
module tb_mem_copy_master;

  import mem_map_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;
  copy_state_t state_dbg;

  mem_copy_master_if mem_bus ();

  assign mem_bus.mem_rd = mem_bus.mem_addr + 32'd1;

  mem_copy_master dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum),
    .mem       (mem_bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];       // {addr, data} of each expected write
  logic [64:0] exp_done_q[$];  // {done edge, error, checksum}
  int n_vec = 0;
  int n_bad = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] w;
    logic [64:0] d;
    if (mem_bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h", mem_bus.mem_addr, mem_bus.mem_wd);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", mem_bus.mem_addr, w[63:32]);
        check("write_data", mem_bus.mem_wd, w[31:0]);
      end
    end
    if (done === 1'b1) begin
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (exp_done_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: at edge %0d", edge_cnt);
      end else begin
        d = exp_done_q.pop_front();
        check("done_edge", 32'(edge_cnt), d[64:33]);
        check("done_error", {31'd0, error}, {31'd0, d[32]});
        check("done_checksum", checksum, d[31:0]);
        check("done_busy", {31'd0, busy}, 32'd1);
      end
    end
    prev_done <= done;
  end

  // ---------------- driver tasks ----------------
  // Issues one request and returns at the negedge after it is accepted.
  task automatic issue_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic exp_err,
                            input int n_wr, input logic exp_done);
    logic [31:0] csum;
    logic [31:0] wa;
    logic [31:0] wd;
    int          k;
    int          n;
    csum = '0;
    @(negedge clk);
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    length   = len;
    @(negedge clk);
    start = 1'b0;
    k = edge_cnt;
    for (int i = 0; i < n_wr; i++) begin
      wa = dst + 32'(i);
      wd = src + 32'(i) + 32'd1;
      exp_q.push_back({wa, wd});
      csum = csum + wd;
    end
`ifndef MEM_COPY_CHECKSUM_EN
    csum = '0;
`endif
    n = (exp_err || len == 32'd0) ? 0 : int'(len);
    if (exp_done) exp_done_q.push_back({32'(k + 1 + 2 * n), exp_err, csum});
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Waits for the expected completions, then checks the idle outputs.
  task automatic wait_done(input logic exp_err);
    for (int i = 0; i < 100 && exp_done_q.size() != 0; i++) @(negedge clk);
    if (exp_done_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: %0d completions outstanding", exp_done_q.size());
      exp_done_q.delete();
    end
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check("idle_addr", mem_bus.mem_addr, 32'd0);
    check("idle_wd", mem_bus.mem_wd, 32'd0);
    check("idle_error_held", {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_bus.mem_we}, 32'd0);
    check({tag, "_addr"}, mem_bus.mem_addr, 32'd0);
    check({tag, "_wd"}, mem_bus.mem_wd, 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Basic copy: ROM 0..3 (1..4) to RAM_LO..RAM_LO+3; checksum 10.
    issue_copy(32'd0, 32'd152100, 32'd4, 1'b0, 4, 1'b1);
    wait_done(1'b0);

    // Zero length: done after one CHECK cycle, no writes, no error.
    issue_copy(32'd0, 32'd152100, 32'd0, 1'b0, 0, 1'b1);
    wait_done(1'b0);

    // Destination below RAM.
    issue_copy(32'd0, 32'd152099, 32'd1, 1'b1, 0, 1'b1);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("error_still_held", {31'd0, error}, 32'd1);

    // Destination runs past RAM_HI.
    issue_copy(32'd0, 32'd305735, 32'd2, 1'b1, 0, 1'b1);
    wait_done(1'b1);

    // Last two RAM words; the start also clears the held error.
    issue_copy(32'd100, 32'd305734, 32'd2, 1'b0, 2, 1'b1);
    wait_done(1'b0);

    // 33-bit overflow of dst+length-1.
    issue_copy(32'd0, 32'd152100, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    wait_done(1'b1);

    // Source end past RAM_HI.
    issue_copy(32'd305730, 32'd152100, 32'd8, 1'b1, 0, 1'b1);
    wait_done(1'b1);

    // Start pulsed during READ with other arguments is ignored.
    issue_copy(32'd20, 32'd152110, 32'd3, 1'b0, 3, 1'b1);
    @(negedge clk);
    start    = 1'b1;
    src_addr = 32'd999;
    dst_addr = 32'd152600;
    length   = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);

    // Reset during the 3rd WRITE of an 8-word copy: exactly 3 words are
    // written, since the 3rd write completes at the reset edge.
    issue_copy(32'd50, 32'd152200, 32'd8, 1'b0, 3, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    repeat (20) @(negedge clk);
    check("midreset_no_more_writes", 32'(exp_q.size()), 32'd0);

    // Recovery after the abandoned copy.
    issue_copy(32'd7, 32'd152300, 32'd1, 1'b0, 1, 1'b1);
    wait_done(1'b0);

    repeat (3) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter RAM_LO, default 152100: lowest legal write address (first RAM word in the unified map).
REQ-002 Parameter RAM_HI, default 305735: highest legal address for both reads and writes.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  32  first source word address; captured on accepted start.
REQ-007 dst_addr  input  32  first destination word address; captured on accepted start.
REQ-008 length  input  32  number of words to copy; captured on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-010 done  output  1  one-cycle pulse at completion, including error completions.
REQ-011 error  output  1  range violation on the last accepted request; held until the next accepted start.
REQ-012 mem_addr  output  32  word address toward the memory controller.
REQ-013 mem_we  output  1  write strobe toward the memory controller.
REQ-014 mem_wd  output  32  write data toward the memory controller.
REQ-015 mem_rd  input  32  combinational read data returned for mem_addr in the same cycle.
REQ-016 checksum  output  32  modulo-2^32 sum of words copied by the last request.

Function
REQ-017 The FSM has states IDLE, CHECK, READ, WRITE and DONE.
REQ-018 IDLE transitions to CHECK when start=1; start while not in IDLE is ignored.
REQ-019 CHECK flags an error when any of these holds: dst_addr<RAM_LO; dst_addr+length-1>RAM_HI; src_addr+length-1>RAM_HI.
REQ-020 All range arithmetic in CHECK uses 33 bits, so 32-bit overflow counts as a violation.
REQ-021 From CHECK, a violation or length=0 goes directly to DONE; otherwise the FSM goes to READ.
REQ-022 Only a violation sets error; length=0 completes with error=0 and no writes.
REQ-023 READ drives mem_addr=current source pointer and mem_we=0, then captures mem_rd into the data register at the edge.
REQ-024 WRITE drives mem_addr=current destination pointer, mem_we=1 and mem_wd=data register.
REQ-025 On each edge leaving WRITE, both pointers increment by 1 and the remaining count decrements by 1.
REQ-026 WRITE goes to DONE when the remaining count reaches 0; otherwise it returns to READ.
REQ-027 Each word takes exactly 2 cycles, so start at edge k gives done=1 in cycle k+2N+2 for N>0 words.
REQ-028 DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-029 mem_we is high only in WRITE.
REQ-030 mem_addr=0 and mem_wd=0 in IDLE, CHECK and DONE.

Reset
REQ-031 Reset forces IDLE and sets busy=0, done=0, error=0, mem_we=0, mem_addr=0, mem_wd=0, checksum=0, pointers=0 and count=0.
REQ-032 Reset during READ or WRITE abandons the copy and suppresses mem_we in the cycle after the reset edge; already-written words are not undone.

Configuration
REQ-033 Macro MEM_COPY_CHECKSUM_EN defined: checksum clears on an accepted start and adds the captured word at each READ edge.
REQ-034 Macro MEM_COPY_CHECKSUM_EN undefined: checksum is tied to 0 and no accumulator logic exists.

Structure
REQ-035 Package mem_map_pkg holds ROM_LO=0, ROM_HI=152099, RAM_LO=152100, RAM_HI=305735 and the copy_state_t enum.
REQ-036 Sub-module copy_checksum (32-bit clearable accumulator) is instantiated only under MEM_COPY_CHECKSUM_EN.

Verification
REQ-037 Copy: src=0, dst=152100, len=4, ROM words 1,2,3,4 -> RAM 152100..152103 = 1..4; done at k+10; checksum=10 when enabled.
REQ-038 Zero length: len=0 -> done at k+2; mem_we never high; error=0.
REQ-039 Range: dst=152099, len=1 -> done at k+2; error=1; no write. Also dst=305735, len=2 -> error=1.
REQ-040 Busy start: start pulsed during READ with different args -> ignored; original copy completes unchanged.
REQ-041 Reset mid-copy: reset in the 3rd WRITE of len=8 -> IDLE; only 2 or 3 words written; all outputs at reset values next cycle.
REQ-042 Boundary: dst=305734, len=2 -> writes 305734 and 305735; error=0; done=1 for exactly one cycle.
